bht_predictor: RTL and testbench
================================

# bht_predictor

Parametrised direct-mapped branch history table with tagged target storage and saturating confidence counters. The IF stage uses it for a same-cycle taken/not-taken prediction and next-PC. The EX stage uses it for registered training on resolved branches. It replaces the stateless per-branch counter update with an indexed, resettable table that counts mispredictions.

## Interface
- ENTRIES, 16: table depth; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2: confidence counter width, 2..4.
- TAG_W, 8: stored tag width; requires IDX_W+TAG_W+2 ≤ 32.
- CNT_W, 16: mispredict statistics counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_if  in  32  fetch PC being looked up.
- pred_hit_if  out  1  valid entry with matching tag.
- pred_taken_if  out  1  hit and counter MSB = 1.
- pred_next_pc_if  out  32  stored target if pred_taken_if, else pc_if + 4.
- upd_valid_ex  in  1  a resolved branch is presented this cycle.
- upd_pc_ex  in  32  PC of the resolved branch.
- upd_taken_ex  in  1  actual outcome.
- upd_target_ex  in  32  actual branch target.
- upd_miss_ex  in  1  the prediction made for this branch was wrong.
- flush_all  in  1  synchronous table invalidate.
- mispred_cnt  out  CNT_W  saturating count of upd_valid_ex && upd_miss_ex.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. The same fields are used for pc_if and upd_pc_ex.
- Each entry holds valid (1b), tag (TAG_W), ctr (CTR_W), target (32).
- Lookup is purely combinational from pc_if and the entry state.
- Lookup, no hit: pred_hit_if=0, pred_taken_if=0, pred_next_pc_if=pc_if+4 (mod 2^32).
- Update, when upd_valid_ex=1 and the entry at the upd index is valid with a matching tag:
  - taken: ctr = min(ctr+1, 2^CTR_W−1), and target = upd_target_ex.
  - not taken: ctr = max(ctr−1, 0); target unchanged.
- Update, when the entry is invalid or the tag mismatches:
  - taken: allocate (overwrite). valid=1, tag written, target=upd_target_ex, ctr = 2^(CTR_W−1) (weak taken).
  - not taken: no write; a not-taken branch never allocates.
- flush_all=1: all valid bits clear at the next edge; ctr, tag and target are kept. flush_all beats a same-cycle update, so the table is empty afterwards.
- mispred_cnt increments on upd_valid_ex && upd_miss_ex, saturates at 2^CNT_W−1, and clears only on reset. It still counts in a flush cycle.
- upd_miss_ex affects only mispred_cnt. Counter training uses only upd_taken_ex.

## Timing
- Reset (rst_n low, asynchronous): all valid=0, every ctr = 2^(CTR_W−1)−1 (weak not-taken), tags and targets 0, mispred_cnt=0.
- Outputs while in reset: pred_hit_if=0, pred_taken_if=0, pred_next_pc_if=pc_if+4.
- Lookup latency is 0 cycles (combinational). Update latency is 1 cycle: state changes at the rising edge where upd_valid_ex=1.
- Same-cycle lookup and update to the same index return the pre-update entry; there is no bypass. The new value is visible the following cycle.
- Reset asserted mid-update discards the update. The first edge after rst_n rises is a normal cycle.
- There are no handshakes. The EX stage must not present an update while stalled, because upd_valid_ex is consumed every cycle it is high.

## Test plan
- Reset with ENTRIES=16, CTR_W=2, TAG_W=8, then pc_if=0x0000_1000 -> pred_hit_if=0, pred_taken_if=0, pred_next_pc_if=0x0000_1004, mispred_cnt=0.
- Allocate and train:
  - Update pc 0x1000, taken, target 0x2000, miss=1 -> next cycle lookup 0x1000 gives hit=1, taken=1, next_pc=0x2000, mispred_cnt=1.
  - A second taken update -> ctr=3.
  - Three not-taken updates -> ctr=0 and taken=0 (3→2→1→0); a fourth not-taken update keeps ctr at 0.
- Tag alias: pc 0x1000 is allocated, then pc 0x1000+(16<<2)=0x1040 is looked up -> hit=0. A taken update to 0x1040 with target 0x3000 replaces the entry, and lookup of 0x1000 then gives hit=0.
- Not-taken miss: an update to pc 0x0500, not taken, on an invalid entry -> no allocation; the lookup stays hit=0.
- Simultaneous events:
  - In one cycle, update 0x1000 taken while pc_if=0x1000 on an empty table -> hit=0 that cycle and hit=1 the next.
  - flush_all together with a taken update -> table empty next cycle, mispred_cnt still increments if upd_miss_ex=1.
- Saturation with CNT_W=4: 20 consecutive mispredicted updates -> mispred_cnt holds at 15. Asserting rst_n=0 asynchronously mid-cycle immediately zeroes mispred_cnt and clears the table.

Source files
------------

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table: combinational fetch-stage lookup,
// registered EX-stage training, and a saturating mispredict counter.
module bht_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_if,
  output logic             pred_hit_if,
  output logic             pred_taken_if,
  output logic [31:0]      pred_next_pc_if,
  input  logic             upd_valid_ex,
  input  logic [31:0]      upd_pc_ex,
  input  logic             upd_taken_ex,
  input  logic [31:0]      upd_target_ex,
  input  logic             upd_miss_ex,
  input  logic             flush_all,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_we;
  logic [CTR_W-1:0] up_ctr, up_ctr_nxt;
  logic             unused_pc;

  assign lk_idx    = pc_if[IDX_W+1:2];
  assign lk_tag    = pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx    = upd_pc_ex[IDX_W+1:2];
  assign up_tag    = upd_pc_ex[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{pc_if, upd_pc_ex};

  // Fetch lookup sees only the current (pre-update) table contents.
  assign pred_hit_if     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_if   = pred_hit_if && ctr_q[lk_idx][CTR_W-1];
  assign pred_next_pc_if = pred_taken_if ? tgt_q[lk_idx] : (pc_if + 32'd4);
  assign mispred_cnt     = cnt_q;

  // Training: saturate on a hit, allocate weak-taken on a taken miss.
  always_comb begin
    up_ctr     = ctr_q[up_idx];
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_we      = upd_valid_ex && (up_hit || upd_taken_ex);
    up_ctr_nxt = CTR_WT;
    if (up_hit) begin
      if (upd_taken_ex) begin
        up_ctr_nxt = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_W'(1);
      end else begin
        up_ctr_nxt = (up_ctr == '0) ? up_ctr : up_ctr - CTR_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid_ex && upd_miss_ex && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flush clears only valid bits and takes priority over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        tgt_q[i]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush_all) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (up_we) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        ctr_q[up_idx]   <= up_ctr_nxt;
        if (upd_taken_ex) begin
          tgt_q[up_idx] <= upd_target_ex;
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: behavioural table model feeding a
// queue of expected lookup results compared each cycle.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_hit_if, pred_taken_if;
  logic [31:0] pred_next_pc_if;
  logic        upd_valid_ex, upd_taken_ex, upd_miss_ex, flush_all;
  logic [31:0] upd_pc_ex, upd_target_ex;
  logic [3:0]  mispred_cnt;

  bht_predictor #(.ENTRIES(16), .CTR_W(2), .TAG_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
    .pred_hit_if(pred_hit_if), .pred_taken_if(pred_taken_if),
    .pred_next_pc_if(pred_next_pc_if),
    .upd_valid_ex(upd_valid_ex), .upd_pc_ex(upd_pc_ex),
    .upd_taken_ex(upd_taken_ex), .upd_target_ex(upd_target_ex),
    .upd_miss_ex(upd_miss_ex), .flush_all(flush_all),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic        m_valid [16];
  logic [7:0]  m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 8'h00; m_ctr[i] = 1; m_tgt[i] = 32'h0;
    end
    m_cnt = 0;
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int   idx;
    idx     = int'((pc >> 2) & 32'hF);
    e.hit   = m_valid[idx] && (m_tag[idx] == pc[13:6]);
    e.taken = e.hit && (m_ctr[idx] >= 2);
    e.npc   = e.taken ? m_tgt[idx] : pc + 32'd4;
    e.cnt   = 4'(m_cnt);
    return e;
  endfunction

  task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic um, input logic fl);
    int   idx;
    logic hit;
    idx = int'((upc >> 2) & 32'hF);
    hit = m_valid[idx] && (m_tag[idx] == upc[13:6]);
    if (uv && um && m_cnt < 15) m_cnt++;
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (hit) begin
        if (ut) begin
          if (m_ctr[idx] < 3) m_ctr[idx]++;
          m_tgt[idx] = utgt;
        end else if (m_ctr[idx] > 0) begin
          m_ctr[idx]--;
        end
      end else if (ut) begin
        m_valid[idx] = 1'b1; m_tag[idx] = upc[13:6];
        m_tgt[idx] = utgt;   m_ctr[idx] = 2;
      end
    end
  endtask

  // One clock: drive after negedge, push expectation, compare, then train model at posedge.
  task automatic cycle(input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um, input logic fl,
                       input logic [31:0] lpc);
    exp_t e;
    pc_if = lpc; upd_valid_ex = uv; upd_pc_ex = upc; upd_taken_ex = ut;
    upd_target_ex = utgt; upd_miss_ex = um; flush_all = fl;
    exp_q.push_back(model_lookup(lpc));
    #2;
    e = exp_q.pop_front();
    check_eq("hit",     32'(pred_hit_if),     32'(e.hit));
    check_eq("taken",   32'(pred_taken_if),   32'(e.taken));
    check_eq("next_pc", pred_next_pc_if,      e.npc);
    check_eq("cnt",     32'(mispred_cnt),     32'(e.cnt));
    @(posedge clk);
    model_update(uv, upc, ut, utgt, um, fl);
    @(negedge clk);
  endtask

  task automatic lookup(input logic [31:0] lpc);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, lpc);
  endtask

  task automatic train(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic um, input logic [31:0] lpc);
    cycle(1'b1, upc, ut, utgt, um, 1'b0, lpc);
  endtask

  logic [31:0] pcs [5];

  initial begin
    rst_n = 1'b0; pc_if = 32'h1000; upd_valid_ex = 1'b0; upd_pc_ex = '0;
    upd_taken_ex = 1'b0; upd_target_ex = '0; upd_miss_ex = 1'b0; flush_all = 1'b0;
    model_reset();
    #12;
    check_eq("rst_hit",   32'(pred_hit_if),   32'd0);
    check_eq("rst_taken", 32'(pred_taken_if), 32'd0);
    check_eq("rst_npc",   pred_next_pc_if,    32'h1004);
    check_eq("rst_cnt",   32'(mispred_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Allocate with same-cycle lookup (no bypass), then train up and down
    train(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h1000);
    lookup(32'h1000);
    train(32'h1000, 1'b1, 32'h2000, 1'b0, 32'h1000);
    for (int i = 0; i < 4; i++) train(32'h1000, 1'b0, 32'h0, 1'b0, 32'h1000);
    lookup(32'h1000);
    train(32'h1000, 1'b1, 32'h2100, 1'b0, 32'h1000);
    lookup(32'h1000);

    // Tag alias replaces the entry
    lookup(32'h1040);
    train(32'h1040, 1'b1, 32'h3000, 1'b1, 32'h1000);
    lookup(32'h1000);
    lookup(32'h1040);

    // Not-taken update on a mismatching/invalid entry never allocates
    train(32'h0500, 1'b0, 32'h9000, 1'b0, 32'h0500);
    lookup(32'h0500);
    train(32'h0504, 1'b0, 32'h9000, 1'b1, 32'h0504);
    lookup(32'h0504);
    lookup(32'h1040);

    // Flush beats a same-cycle taken update; miss still counted
    cycle(1'b1, 32'h1080, 1'b1, 32'h4000, 1'b1, 1'b1, 32'h1040);
    lookup(32'h1080);
    lookup(32'h1040);

    // Mispredict counter saturation
    for (int i = 0; i < 20; i++) train(32'h1040, 1'b1, 32'h5000, 1'b1, 32'h1040);
    lookup(32'h1040);

    // Asynchronous reset mid-cycle during an update
    pc_if = 32'h1040; upd_valid_ex = 1'b1; upd_pc_ex = 32'h1040; upd_taken_ex = 1'b1;
    upd_miss_ex = 1'b1; upd_target_ex = 32'h6000;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_cnt", 32'(mispred_cnt),   32'd0);
    check_eq("async_hit", 32'(pred_hit_if),   32'd0);
    check_eq("async_npc", pred_next_pc_if,    32'h1044);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    upd_valid_ex = 1'b0;
    rst_n = 1'b1;
    lookup(32'h1040);

    // Mixed random traffic over a few colliding PCs
    pcs[0] = 32'h1000; pcs[1] = 32'h1040; pcs[2] = 32'h1004;
    pcs[3] = 32'h2008; pcs[4] = 32'h0500;
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            pcs[$urandom_range(0, 4)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
